// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_sequencer_load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load still sitting in ID/EX.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs1_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] id_ex_rd_i,
    input  logic       id_ex_mem_read_i,
    output logic       lu_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1_i && (id_rs1_i == id_ex_rd_i);
    assign rs2_hit = id_uses_rs2_i && (id_rs2_i == id_ex_rd_i);
    assign lu_o    = id_ex_mem_read_i && (id_ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_sequencer.sv
// Central stall/flush scheduler: memory wait > mispredict > load-use, with a
// pending-redirect latch for mispredicts that resolve during a memory wait.
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic            id_ex_mem_read,
    input  logic            ex_mem_branch_resolved,
    input  logic            ex_mem_branch_taken_actual,
    input  logic            ex_mem_branch_predicted_taken,
    input  logic [XLEN-1:0] ex_mem_branch_target_actual,
    input  logic [XLEN-1:0] ex_mem_pc_plus_4,
    input  logic            mem_busy,
    output logic            stall_pc,
    output logic            stall_if_id,
    output logic            stall_id_ex,
    output logic            stall_ex_mem,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] stall_cycles,
    output logic [XLEN-1:0] flush_events
);

    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic [XLEN-1:0]   stall_cycles_q, flush_events_q;

    logic              lu_raw;
    logic              lu;
    logic              mp;
    logic [XLEN-1:0]   corr_target;

    load_use_detect u_lu (
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_uses_rs1_i    (id_uses_rs1),
        .id_uses_rs2_i    (id_uses_rs2),
        .id_ex_rd_i       (id_ex_rd),
        .id_ex_mem_read_i (id_ex_mem_read),
        .lu_o             (lu_raw)
    );

    // The cycle after a redirect, ID holds a squashed instruction, so its hazards are void.
    assign lu          = lu_raw && (state_q != REDIRECT);
    assign mp          = ex_mem_branch_resolved &&
                         (ex_mem_branch_taken_actual != ex_mem_branch_predicted_taken);
    assign corr_target = ex_mem_branch_taken_actual ? ex_mem_branch_target_actual
                                                    : ex_mem_pc_plus_4;

    always_comb begin
        state_d         = state_q;
        pend_valid_d    = pend_valid_q;
        pend_target_d   = pend_target_q;
        stall_pc        = 1'b0;
        stall_if_id     = 1'b0;
        stall_id_ex     = 1'b0;
        stall_ex_mem    = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        pc_redirect     = 1'b0;
        redirect_target = '0;
        if (rst) begin
            state_d = RUN;
        end else if (mem_busy) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            state_d      = MEM_WAIT;
            if (mp) begin
                pend_valid_d  = 1'b1;
                pend_target_d = corr_target;
            end
        end else if (state_q == MEM_WAIT && pend_valid_q) begin
            // A live mispredict on the wait's last cycle is younger, so it wins.
            pc_redirect     = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            redirect_target = mp ? corr_target : pend_target_q;
            pend_valid_d    = 1'b0;
            state_d         = REDIRECT;
        end else if (mp) begin
            pc_redirect     = 1'b1;
            if_id_flush     = 1'b1;
            id_ex_flush     = 1'b1;
            redirect_target = corr_target;
            state_d         = REDIRECT;
        end else if (lu) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            pend_valid_q   <= 1'b0;
            pend_target_q  <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_valid_q   <= pend_valid_d;
            pend_target_q  <= pend_target_d;
            stall_cycles_q <= stall_cycles_q + {{(XLEN-1){1'b0}}, stall_pc};
            flush_events_q <= flush_events_q + {{(XLEN-1){1'b0}}, pc_redirect};
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: vector table, directed multi-cycle
// sequences and a randomized run against a rule-level reference model.
module tb_hazard_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_ex_rd;
    logic        id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic        br_res, br_tk, br_pt, mem_busy;
    logic [31:0] br_tgt, br_pc4;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
    logic        if_id_flush, id_ex_flush, pc_redirect;
    logic [31:0] redirect_target, stall_cycles, flush_events;

    int nchecks = 0;
    int nerr    = 0;

    hazard_sequencer #(.XLEN(32)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .id_rs1                        (id_rs1),
        .id_rs2                        (id_rs2),
        .id_uses_rs1                   (id_uses_rs1),
        .id_uses_rs2                   (id_uses_rs2),
        .id_ex_rd                      (id_ex_rd),
        .id_ex_mem_read                (id_ex_mem_read),
        .ex_mem_branch_resolved        (br_res),
        .ex_mem_branch_taken_actual    (br_tk),
        .ex_mem_branch_predicted_taken (br_pt),
        .ex_mem_branch_target_actual   (br_tgt),
        .ex_mem_pc_plus_4              (br_pc4),
        .mem_busy                      (mem_busy),
        .stall_pc                      (stall_pc),
        .stall_if_id                   (stall_if_id),
        .stall_id_ex                   (stall_id_ex),
        .stall_ex_mem                  (stall_ex_mem),
        .if_id_flush                   (if_id_flush),
        .id_ex_flush                   (id_ex_flush),
        .pc_redirect                   (pc_redirect),
        .redirect_target               (redirect_target),
        .stall_cycles                  (stall_cycles),
        .flush_events                  (flush_events)
    );

    always #5 clk = ~clk;

    // flags order: stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, if_id_flush, id_ex_flush, pc_redirect
    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, mr, res, tk, pt, mb;
        logic [31:0] tgt, pc4;
        logic [6:0]  exp_flags;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] flags();
        return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, if_id_flush, id_ex_flush, pc_redirect};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic [4:0] rd, input logic mr, input logic res, input logic tk,
                          input logic pt, input logic [31:0] tgt, input logic [31:0] pc4, input logic mb);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_rd = rd; id_ex_mem_read = mr; br_res = res; br_tk = tk; br_pt = pt;
        br_tgt = tgt; br_pc4 = pc4; mem_busy = mb;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model state, expressed as the spec's rules rather than an FSM encoding.
    bit          m_waiting, m_after_redirect, m_pend;
    logic [31:0] m_ptgt, m_stalls, m_flushes;
    logic [6:0]  e_flags;
    logic [31:0] e_rt;

    task automatic model_reset();
        m_waiting = 0; m_after_redirect = 0; m_pend = 0;
        m_ptgt = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_eval();
        bit          mp, lu;
        logic [31:0] corr;
        mp   = br_res && (br_tk != br_pt);
        corr = br_tk ? br_tgt : br_pc4;
        lu   = id_ex_mem_read && id_ex_rd != 0 &&
               ((id_uses_rs1 && id_rs1 == id_ex_rd) || (id_uses_rs2 && id_rs2 == id_ex_rd));
        e_flags = 7'b0;
        e_rt    = 32'h0;
        if (mem_busy) begin
            e_flags = 7'b1111000;
            if (mp) begin m_pend = 1; m_ptgt = corr; end
            m_waiting = 1; m_after_redirect = 0;
        end else if (m_waiting && m_pend) begin
            e_flags = 7'b0000111;
            e_rt    = mp ? corr : m_ptgt;
            m_pend  = 0; m_waiting = 0; m_after_redirect = 1;
        end else if (mp) begin
            e_flags = 7'b0000111;
            e_rt    = corr;
            m_waiting = 0; m_after_redirect = 1;
        end else begin
            if (lu && !m_after_redirect) e_flags = 7'b1100010;
            m_waiting = 0; m_after_redirect = 0;
        end
        m_stalls  += {31'b0, e_flags[6]};
        m_flushes += {31'b0, e_flags[0]};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("reset_flags", {57'b0, flags()}, 64'h0);
        chk("reset_target", {32'b0, redirect_target}, 64'h0);
        chk("reset_counters", {stall_cycles, flush_events}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // rs1, rs2, rd, u1, u2, mr, res, tk, pt, mb, tgt, pc4, flags, rt
        vecs[0] = '{5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, 0, 0, 32'h0,  32'h0,    7'b1100010, 32'h0};
        vecs[1] = '{5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 0, 0, 0, 32'h0,  32'h0,    7'b0000000, 32'h0};
        vecs[2] = '{5'd5, 5'd0, 5'd5, 0, 0, 1, 0, 0, 0, 0, 32'h0,  32'h0,    7'b0000000, 32'h0};
        vecs[3] = '{5'd1, 5'd7, 5'd7, 1, 1, 1, 0, 0, 0, 0, 32'h0,  32'h0,    7'b1100010, 32'h0};
        vecs[4] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 32'h40, 32'h1004, 7'b0000111, 32'h40};
        vecs[5] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 0, 32'h40, 32'h1004, 7'b0000111, 32'h1004};
        vecs[6] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 1, 0, 32'h40, 32'h1004, 7'b0000000, 32'h0};
        vecs[7] = '{5'd3, 5'd0, 5'd3, 1, 0, 1, 1, 1, 0, 0, 32'h100, 32'h8,   7'b0000111, 32'h100};
        vecs[8] = '{5'd3, 5'd0, 5'd3, 1, 0, 1, 1, 1, 0, 1, 32'h100, 32'h8,   7'b1111000, 32'h0};
        vecs[9] = '{5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 0, 0, 0, 32'h0,  32'h0,    7'b0000000, 32'h0};

        for (int i = 0; i < 10; i++) begin
            do_reset();
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd, vecs[i].mr,
                   vecs[i].res, vecs[i].tk, vecs[i].pt, vecs[i].tgt, vecs[i].pc4, vecs[i].mb);
            #1;
            chk($sformatf("vec%0d_flags", i), {57'b0, flags()}, {57'b0, vecs[i].exp_flags});
            chk($sformatf("vec%0d_target", i), {32'b0, redirect_target}, {32'b0, vecs[i].exp_rt});
        end

        // Load-use stalls exactly one cycle.
        do_reset();
        set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        #1 chk("lu_first", {57'b0, flags()}, {57'b0, 7'b1100010});
        @(negedge clk);
        idle();
        #1 chk("lu_after", {57'b0, flags()}, 64'h0);
        chk("lu_stall_cycles", {32'b0, stall_cycles}, 64'd1);

        // Mispredict, then load-use ignored in REDIRECT, then honoured again.
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 32'h40, 32'h4, 0);
        #1 chk("mp_flags", {57'b0, flags()}, {57'b0, 7'b0000111});
        chk("mp_target", {32'b0, redirect_target}, 64'h40);
        @(negedge clk);
        set_in(5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, 32'h0, 32'h0, 0);
        #1 chk("redirect_lu_ignored", {57'b0, flags()}, 64'h0);
        chk("mp_flush_events", {32'b0, flush_events}, 64'd1);
        @(negedge clk);
        #1 chk("lu_after_redirect", {57'b0, flags()}, {57'b0, 7'b1100010});

        // Memory wait for 3 cycles with a mispredict in the second.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 32'h80, 32'h4, 1);
            else        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 32'h0, 32'h0, 1);
            #1 chk($sformatf("wait%0d_flags", c), {57'b0, flags()}, {57'b0, 7'b1111000});
            @(negedge clk);
        end
        idle();
        #1 chk("wait_release_flags", {57'b0, flags()}, {57'b0, 7'b0000111});
        chk("wait_release_target", {32'b0, redirect_target}, 64'h80);
        chk("wait_stall_cycles", {32'b0, stall_cycles}, 64'd3);
        @(negedge clk);
        #1 chk("wait_flush_events", {32'b0, flush_events}, 64'd1);

        // Live mispredict on the cycle mem_busy falls overrides the pending one.
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 32'h80, 32'h4, 1);
        @(negedge clk);
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 32'h200, 32'h4, 0);
        #1 chk("coincide_target", {32'b0, redirect_target}, 64'h200);
        @(negedge clk);
        idle();
        #1 chk("coincide_no_second", {57'b0, flags()}, 64'h0);
        @(negedge clk);
        #1 chk("coincide_no_third", {57'b0, flags()}, 64'h0);
        chk("coincide_flush_events", {32'b0, flush_events}, 64'd1);

        // Reset during a memory wait discards the pending redirect.
        do_reset();
        set_in(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, 32'h300, 32'h4, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_mid_flags", {57'b0, flags()}, 64'h0);
        chk("rst_mid_counters", {stall_cycles, flush_events}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1 chk("rst_no_redirect", {57'b0, flags()}, 64'h0);
        chk("rst_counters", {stall_cycles, flush_events}, 64'h0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                   ($urandom_range(0, 3) == 0), $urandom, $urandom,
                   ($urandom_range(0, 3) == 0));
            #1;
            chk($sformatf("rnd%0d_counters", n), {stall_cycles, flush_events}, {m_stalls, m_flushes});
            model_eval();
            chk($sformatf("rnd%0d_flags", n), {57'b0, flags()}, {57'b0, e_flags});
            chk($sformatf("rnd%0d_target", n), {32'b0, redirect_target}, {32'b0, e_rt});
        end
        @(negedge clk);
        idle();
        #1 chk("rnd_final_counters", {stall_cycles, flush_events}, {m_stalls, m_flushes});

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Central stall/flush scheduler for the 5-stage core. It takes hazard inputs from the ID, EX and MEM stages and produces every pipeline-register enable and flush, plus the PC redirect. It replaces per-stage ad-hoc hazard logic with one prioritised state machine. It also latches mispredicts that arrive during a memory wait and keeps 32-bit stall and flush event counters.

## Interface
- `XLEN`, 32: width of PC, target and counters.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1 each  the ID instruction actually reads that source.
- `id_ex_rd`  in  5  destination register in ID/EX.
- `id_ex_mem_read`  in  1  the ID/EX instruction is a load.
- `ex_mem_branch_resolved`  in  1  a branch or jump resolved in EX/MEM this cycle.
- `ex_mem_branch_taken_actual`  in  1  actual outcome.
- `ex_mem_branch_predicted_taken`  in  1  predicted outcome. Currently tied to 0.
- `ex_mem_branch_target_actual`  in  XLEN  taken target.
- `ex_mem_pc_plus_4`  in  XLEN  fall-through PC of the branch.
- `mem_busy`  in  1  data memory wait request.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`  out  1 each  hold the register.
- `if_id_flush`, `id_ex_flush`  out  1 each  load a bubble.
- `pc_redirect`  out  1  PC loads `redirect_target` next edge.
- `redirect_target`  out  XLEN  corrected PC.
- `stall_cycles`, `flush_events`  out  XLEN  event counters.

## Operation
- States: RUN, MEM_WAIT, REDIRECT. Reset state is RUN.
- Mispredict condition `mp`: `ex_mem_branch_resolved` and actual outcome differs from predicted outcome.
- Corrected target: `ex_mem_branch_target_actual` if the branch was actually taken, else `ex_mem_pc_plus_4`.
- Load-use condition `lu`, all of the following must hold:
  - `id_ex_mem_read`;
  - `id_ex_rd` is not 0;
  - (`id_uses_rs1` and `id_rs1` equals `id_ex_rd`) or (`id_uses_rs2` and `id_rs2` equals `id_ex_rd`).
  - `lu` is forced to 0 in REDIRECT.
- Priority: `mem_busy` first, then pending or live mispredict, then `lu`.
- `mem_busy` high, in any state:
  - assert all four stall outputs; no flush, no redirect;
  - if `mp`, latch `pend_valid`=1 and `pend_target`=corrected target;
  - if `pend_valid` is already set, a second `mp` overwrites `pend_target`;
  - next state is MEM_WAIT.
- MEM_WAIT with `mem_busy` low:
  - if `pend_valid`, apply the redirect from `pend_target`, clear `pend_valid`, go to REDIRECT;
  - otherwise evaluate as RUN.
- RUN or REDIRECT with `mem_busy` low:
  - `mp`: `pc_redirect`=1, `if_id_flush`=1, `id_ex_flush`=1, no stalls, go to REDIRECT. Overrides `lu`.
  - else `lu`: `stall_pc`=1, `stall_if_id`=1, `id_ex_flush`=1, stay in RUN (also from REDIRECT).
  - else: all outputs 0, go to RUN.
- REDIRECT lasts one cycle. A second mispredict in REDIRECT is serviced normally.
- `stall_cycles` increments on every cycle where `stall_pc` is 1.
- `flush_events` increments on every cycle where `pc_redirect` is 1.
- Both counters wrap modulo 2^XLEN.

## Timing
- All control outputs are combinational from the inputs, the state and the pending registers, so they are valid in the same cycle. State, pending registers and counters update on the `clk` rising edge.
- Reset values: state RUN, `pend_valid` 0, `pend_target` 0, counters 0.
- During reset all outputs are 0 and `redirect_target` is 0.
- `redirect_target` is 0 whenever `pc_redirect` is 0.
- A mispredict coinciding with the falling edge of `mem_busy` (`mem_busy`=0 and a live `mp` in MEM_WAIT with `pend_valid`): the live `mp` wins, `pend_valid` is cleared, and one redirect is counted.
- Reset asserted mid-MEM_WAIT discards the pending redirect.

## Structure
- Shared package `hazard_pkg`:
  - state enum encoding: RUN=2'd0, MEM_WAIT=2'd1, REDIRECT=2'd2;
  - `REG_ZERO`=5'd0.
- One sub-module, `load_use_detect`: the combinational `lu` comparator.
- FSM, pending latch and counters live in the top module.

## Test plan
- `id_ex_mem_read`=1, `id_ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 -> for exactly one cycle, `stall_pc`=`stall_if_id`=`id_ex_flush`=1; `stall_cycles`=1.
- Same as above but `id_ex_rd`=0, or `id_uses_rs1`=0 -> no stall.
- Mispredict: resolved=1, taken=1, predicted=0, target=0x40 -> `pc_redirect`=1, `redirect_target`=0x40, both flushes high; next cycle state is REDIRECT and `lu` is ignored; `flush_events`=1.
- `mem_busy` held 3 cycles with a mispredict (target 0x80) in cycle 2 -> all stalls high for 3 cycles, no redirect; in the cycle after `mem_busy` falls, `pc_redirect`=1 with target 0x80.
- Live `mp` (target 0x100) together with a load-use match -> redirect to 0x100, no `stall_pc`.
- `rst` pulsed while `pend_valid`=1 -> no redirect after release; counters read 0.
